// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronized per-channel edge detection with one-deep queues,
// served round-robin onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter  int CH   = 4,
  parameter  int SYNC = 2,
  localparam int CW   = $clog2(CH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CH-1:0] i_cin,
  input  logic [CH-1:0] i_pos_en,
  input  logic [CH-1:0] i_neg_en,
  output logic          o_ev_valid,
  input  logic          i_ev_ready,
  output logic [CW-1:0] o_ev_ch,
  output logic          o_ev_pol,
  output logic [CH-1:0] o_pend,
  output logic [CH-1:0] o_ovf,
  input  logic          i_ovf_clr
);
  localparam int AW = $clog2(SYNC + 2);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t                  r_state, w_state_nxt;
  logic [SYNC-1:0][CH-1:0] r_sync;
  logic [CH-1:0]           r_prev, r_pend, r_pol, r_ovf;
  logic [CH-1:0]           w_rise, w_fall, w_edge, w_ld, w_wr;
  logic [AW-1:0]           r_arm;
  logic                    w_armed, w_any, w_load, r_ev_pol;
  logic [CW-1:0]           r_ptr, r_ch, w_win;
  logic [CW:0]             w_idx;
  // detection stays off until prev has caught up with a line that was already high at reset
  assign w_armed = r_arm == AW'(SYNC + 1);
  assign w_rise  = {CH{w_armed}} & r_sync[SYNC-1] & ~r_prev & i_pos_en;
  assign w_fall  = {CH{w_armed}} & ~r_sync[SYNC-1] & r_prev & i_neg_en;
  assign w_edge  = w_rise | w_fall;
  assign w_any   = |r_pend;
  assign w_load  = w_any & (r_state == IDLE | i_ev_ready);
  assign w_ld    = w_load ? CH'(1) << w_win : '0;
  assign w_wr    = w_edge & (~r_pend | w_ld);
  // scan downward so the entry closest to ptr is the last to be written
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (CW+1)'(k);
      w_idx = w_idx >= (CW+1)'(CH) ? w_idx - (CW+1)'(CH) : w_idx;
      w_win = r_pend[w_idx[CW-1:0]] ? w_idx[CW-1:0] : w_win;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == IDLE ? (w_any ? OFFER : IDLE) : (i_ev_ready & ~w_any ? IDLE : OFFER);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_prev   <= '0;
      r_arm    <= '0;
      r_pend   <= '0;
      r_pol    <= '0;
      r_ovf    <= '0;
      r_ptr    <= '0;
      r_ch     <= '0;
      r_ev_pol <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC-2:0], i_cin};
      r_prev  <= r_sync[SYNC-1];
      r_arm   <= w_armed ? r_arm : r_arm + 1'b1;
      r_pend  <= (r_pend & ~w_ld) | w_edge;
      r_pol   <= (r_pol & ~w_wr) | (w_rise & w_wr);
      r_ovf   <= (r_ovf & ~{CH{i_ovf_clr}}) | (w_edge & r_pend & ~w_ld);
      if (w_load) begin
        r_ch     <= w_win;
        r_ev_pol <= r_pol[w_win];
        r_ptr    <= w_win == CW'(CH - 1) ? '0 : w_win + 1'b1;
      end
    end
  end
  assign o_ev_valid = r_state == OFFER;
  assign o_ev_ch    = r_ch;
  assign o_ev_pol   = r_ev_pol;
  assign o_pend     = r_pend;
  assign o_ovf      = r_ovf;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vectors, corner sequences and randomized traffic against a reference model.
module tb_edge_event_arbiter;
  localparam int CH = 4;
  localparam int SYNC = 2;
  localparam int CW = 2;
  logic          clk, rst_n, ready, ovf_clr;
  logic [CH-1:0] cin, pos_en, neg_en;
  logic          o_ev_valid, o_ev_pol;
  logic [CW-1:0] o_ev_ch;
  logic [CH-1:0] o_pend, o_ovf;
  int n_checks = 0;
  int n_errors = 0;
  edge_event_arbiter #(.CH(CH), .SYNC(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cin(cin), .i_pos_en(pos_en), .i_neg_en(neg_en),
    .o_ev_valid(o_ev_valid), .i_ev_ready(ready), .o_ev_ch(o_ev_ch), .o_ev_pol(o_ev_pol),
    .o_pend(o_pend), .o_ovf(o_ovf), .i_ovf_clr(ovf_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference model: sampled-input history plus per-channel pending slots and one offered slot
  logic [CH-1:0] m_samp[$];
  logic [CH-1:0] m_pend, m_ppol, m_ovf;
  logic          m_valid, m_opol;
  logic [CW-1:0] m_ch;
  int            m_ptr;
  task automatic model_reset();
    m_samp.delete();
    m_pend = '0; m_ppol = '0; m_ovf = '0;
    m_valid = 1'b0; m_opol = 1'b0; m_ch = '0; m_ptr = 0;
  endtask
  task automatic model_edge();
    logic [CH-1:0] s, p, rise, fall;
    int n, w;
    bit armed;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n = m_samp.size();
    s = n >= SYNC ? m_samp[n-SYNC] : '0;
    p = n >= SYNC + 1 ? m_samp[n-SYNC-1] : '0;
    armed = n >= SYNC + 1;
    m_samp.push_back(cin);
    rise = armed ? (s & ~p & pos_en) : '0;
    fall = armed ? (~s & p & neg_en) : '0;
    if (ovf_clr) m_ovf = '0;
    if (!m_valid || ready) begin
      w = -1;
      for (int k = 0; k < CH; k++)
        if (w < 0 && m_pend[(m_ptr + k) % CH]) w = (m_ptr + k) % CH;
      if (w >= 0) begin
        m_valid = 1'b1; m_ch = CW'(w); m_opol = m_ppol[w]; m_pend[w] = 1'b0; m_ptr = (w + 1) % CH;
      end else m_valid = 1'b0;
    end
    for (int i = 0; i < CH; i++)
      if (rise[i] || fall[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        else begin m_pend[i] = 1'b1; m_ppol[i] = rise[i]; end
      end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("model", {o_ev_valid, o_ev_ch, o_ev_pol, o_pend, o_ovf}, {m_valid, m_ch, m_opol, m_pend, m_ovf});
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask
  task automatic wait_valid(input int budget);
    int k = 0;
    while (!o_ev_valid && k < budget) begin
      step();
      k++;
    end
    chk("wait_valid", 32'(o_ev_valid), 1);
  endtask
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    step();
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic [CH-1:0] cin, pos, neg;
    logic          rdy, v;
    logic [CW-1:0] ch;
    logic          pol;
    logic [CH-1:0] pend;
  } vec_t;
  vec_t tbl[17];
  int cnt, quiet;
  initial begin
    tbl[0]  = '{4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010};
    tbl[3]  = '{4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000};
    tbl[4]  = '{4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[10] = '{4'b1000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[11] = '{4'b1000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1000};
    tbl[15] = '{4'b0000, 4'b0111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0111, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    rst_n = 1'b0; cin = '0; pos_en = '1; neg_en = '1; ready = 1'b1; ovf_clr = 1'b0;
    model_reset();
    step();
    chk("reset_state", {o_ev_valid, o_ev_ch, o_ev_pol, o_pend, o_ovf}, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    for (int i = 0; i < 17; i++) begin
      cin = tbl[i].cin; pos_en = tbl[i].pos; neg_en = tbl[i].neg; ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d", i), {o_ev_valid, o_ev_ch, o_ev_pol, o_pend, o_ovf},
          {tbl[i].v, tbl[i].ch, tbl[i].pol, tbl[i].pend, 4'b0000});
    end
    // fairness: ptr is 0 here, then 3 after serving ch2
    pos_en = '1; neg_en = '0; ready = 1'b1; cin = 4'b0101;
    wait_valid(8);
    chk("fair_first", 32'(o_ev_ch), 0);
    step();
    chk("fair_second", {o_ev_valid, o_ev_ch}, {1'b1, 2'd2});
    cin = 4'b0000;
    repeat (6) step();
    cin = 4'b1001;
    wait_valid(8);
    chk("fair_wrap_first", 32'(o_ev_ch), 3);
    step();
    chk("fair_wrap_second", {o_ev_valid, o_ev_ch}, {1'b1, 2'd0});
    // backpressure and overflow on ch0
    pos_en = '0; neg_en = '0; cin = 4'b0000;
    repeat (6) step();
    pos_en = 4'b0001; neg_en = 4'b0001; ready = 1'b0; cin = 4'b0001;
    wait_valid(8);
    chk("bp_offer", {o_ev_ch, o_ev_pol}, {2'd0, 1'b1});
    cin = 4'b0000;
    repeat (4) step();
    cin = 4'b0001;
    repeat (4) step();
    chk("bp_hold", {o_ev_valid, o_ev_ch, o_ev_pol}, {1'b1, 2'd0, 1'b1});
    chk("bp_ovf", {o_pend, o_ovf}, {4'b0001, 4'b0001});
    ready = 1'b1;
    cnt = 0;
    repeat (4) begin
      if (o_ev_valid) cnt++;
      step();
    end
    chk("bp_delivered", 32'(cnt), 2);
    chk("ovf_sticky", 32'(o_ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(o_ovf), 0);
    // lines high through reset must not produce events
    pos_en = '1; neg_en = '1; cin = 4'b1111; rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    quiet = 0;
    repeat (8) begin
      step();
      if (o_ev_valid || o_pend != 0) quiet++;
    end
    chk("reset_high_quiet", 32'(quiet), 0);
    ready = 1'b0; cin = 4'b0000;
    wait_valid(8);
    cin = 4'b1111;
    repeat (4) step();
    chk("midrst_pend_nz", 32'(o_pend != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", {o_ev_valid, o_pend, o_ovf}, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    // randomized traffic
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) cin[i] = ~cin[i];
      if ($urandom_range(0, 15) == 0) begin
        pos_en = CH'($urandom);
        neg_en = CH'($urandom);
      end
      ready = $urandom_range(0, 3) != 0;
      ovf_clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 499) == 0) mid_reset();
      else step();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller that samples CH asynchronous input lines and detects rising and falling edges per channel under per-polarity enables. Detected events are queued one deep per channel and served through a fair round-robin arbiter onto a single valid/ready event port. It sits between raw level signals and a single downstream event consumer, sequencing and sharing the edge-detection function across channels.

## Interface
- CH, 4: number of input channels, 2..16
- SYNC, 2: synchronizer depth in flops, ≥2
- CW, $clog2(CH): channel-id width, derived, not overridable
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset; one clock domain
- Cin  in  CH  raw asynchronous level inputs
- Pos_En  in  CH  per-channel rising-edge enable
- Neg_En  in  CH  per-channel falling-edge enable
- Ev_Valid  out  1  event offered
- Ev_Ready  in  1  consumer accepts event
- Ev_Ch  out  CW  channel of offered event
- Ev_Pol  out  1  1 = rising, 0 = falling
- Pend  out  CH  per-channel pending flags
- Ovf  out  CH  sticky per-channel overflow flags
- Ovf_Clr  in  1  synchronous clear of all Ovf bits

## Operation
- Per channel: SYNC-flop synchronizer, then prev register. Rise = sync & ~prev & Pos_En; fall = ~sync & prev & Neg_En.
- Arm: counter after reset; edge detection is gated off until SYNC+1 cycles after Rst_n deasserts, so a line already high at reset produces no event.
- Pending store: pend[i] plus pol[i]. An edge sets pend[i] and writes pol[i] when pend[i]=0, or when channel i is being loaded to the output in the same cycle (the new edge is kept and is not an overflow).
- Otherwise, an edge with pend[i]=1 is dropped, the oldest event is kept, and Ovf[i] is set. When overflow and Ovf_Clr occur in the same cycle, set wins.
- Changing Pos_En or Neg_En does not affect events already pending.
- Arbiter: round-robin pointer ptr (CW bits). The winner is the first pend[i]=1 scanning ptr, ptr+1, … modulo CH. On load, ptr becomes winner+1 modulo CH, with wrap at CH-1 to 0 and correct wrap for non-power-of-2 CH.
- FSM IDLE: Ev_Valid=0. If any pend is set, load the winner into Ev_Ch/Ev_Pol, clear its pend bit, and go to OFFER.
- FSM OFFER: Ev_Valid=1. Ev_Ch and Ev_Pol are held stable while Ev_Ready=0.
- On Ev_Valid & Ev_Ready: if any pend is set, load the next winner in the same cycle and stay in OFFER (back-to-back, one event per cycle). Otherwise go to IDLE.
- Pend reflects the store only; an event in the output register is not pending.
- Reset values: Ev_Valid=0, Ev_Ch=0, Ev_Pol=0, Pend=0, Ovf=0. Internal state at reset: ptr=0, sync and prev registers=0, Arm=0, FSM=IDLE.
- Reset mid-operation: an offered event and all pending events are discarded immediately (asynchronous reset). Arm restarts.

## Timing
- Cin transition stable before rising edge E0 produces Ev_Valid=1 after edge E0+SYNC+1. For SYNC=2 this is after E3.
- Pend[i] rises one cycle before Ev_Valid when FSM is IDLE.
- Throughput: one event per cycle while Ev_Ready=1.
- Maximum arbitration wait: CH-1 grants.
- Ev_Valid never drops without a handshake, except on reset.
- Ovf_Clr takes effect on the next edge.
- All outputs are registered. There is no combinational path from Ev_Ready to Ev_Valid, Ev_Ch or Ev_Pol.

## Test plan
- Single edge: CH=4, SYNC=2, all enables 1, Ev_Ready=1. Cin[1] goes 0→1 before E0. Required: Ev_Valid=1, Ev_Ch=1, Ev_Pol=1 after E3 for exactly one cycle. Cin[1] then goes 1→0, giving the same timing with Ev_Pol=0.
- Fairness: Cin[0] and Cin[2] rise in the same cycle, ptr=0, Ev_Ready=1. Required: ch0 then ch2 on consecutive cycles. Then ch0 and ch3 rise together. Required: ch3 before ch0.
- Backpressure and overflow: Ev_Ready=0 with an event offered on ch0. Cin[0] toggles twice more. Required: Ev_Ch and Ev_Pol are held stable, Ovf[0]=1, and after Ev_Ready=1 exactly two ch0 events are delivered. Ovf_Clr then clears Ovf to 0.
- Enables: Pos_En=0, Neg_En=1 on ch3, Cin[3] pulses 0→1→0. Required: only one event, Ev_Pol=0.
- Reset behaviour: Cin=4'b1111 during reset, then release. Required: no events. Asserting Rst_n=0 while Ev_Valid=1 and Pend≠0 requires Ev_Valid=0, Pend=0 and Ovf=0 immediately.
